regfile_write_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: A (ALU result) and B (memory load).
- Arbitration is round-robin with valid/ready handshakes.
- Writes to register 0 are absorbed without using the port.
- The winner is registered onto the register file's reg_write/write_reg/write_data inputs, one cycle after grant.

---
 rtl/regfile_write_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between A (ALU) and B (load).
// Optional conflict statistics counter: define WB_ARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Handshake: a request transfers in any cycle where valid && ready are both high;
  // an unaccepted requester keeps valid/reg/data stable until it sees ready.
  logic a_real, b_real, a_null, b_null;
  logic grant_a, grant_b, open;
  logic prio; // 0: A preferred on contention, 1: B preferred

  assign a_real = a_valid && (a_reg != '0);
  assign b_real = b_valid && (b_reg != '0);
  assign a_null = a_valid && (a_reg == '0);
  assign b_null = b_valid && (b_reg == '0);

  assign open    = !hold && !reset;
  assign grant_a = open && a_real && (!b_real || !prio);
  assign grant_b = open && b_real && (!a_real ||  prio);

  // Writes to register 0 are absorbed without touching the port.
  assign a_ready = grant_a || (open && a_null);
  assign b_ready = grant_b || (open && b_null);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      prio       <= 1'b0;
    end else begin
      reg_write <= grant_a || grant_b;
      if (grant_a) begin
        write_reg  <= a_reg;
        write_data <= a_data;
        prio       <= 1'b1;
      end else if (grant_b) begin
        write_reg  <= b_reg;
        write_data <= b_data;
        prio       <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!hold && a_real && b_real && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
